// File: rtl/pbs_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pbs_pkg
// Brief   : Shared types and constants for the battle sequencer.
// Revision: 1.0 - initial release
// ============================================================================
package pbs_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    P_RES = 3'd1,
    P_APP = 3'd2,
    A_RES = 3'd3,
    A_APP = 3'd4,
    OVER  = 3'd5
  } state_t;

  localparam int          c_LFSR_W       = 16;
  // Taps 16,14,13,11 expressed as a mask over bits [15:0]
  localparam logic [15:0] c_LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] c_DEF_MOVE_DMG = {4'd7, 4'd5, 4'd3, 4'd1};
  localparam logic [15:0] c_DEF_MOVE_ACC = {4'd8, 4'd11, 4'd14, 4'd15};

  function automatic logic [c_LFSR_W-1:0] lfsr_next(input logic [c_LFSR_W-1:0] i_s);
    return {i_s[c_LFSR_W-2:0], ^(i_s & c_LFSR_TAPS)};
  endfunction

endpackage
`default_nettype wire

// File: rtl/pbs_lfsr.sv
`default_nettype none
// ============================================================================
// Module  : pbs_lfsr
// Brief   : 16-bit Fibonacci LFSR with freeze control; reproducible RNG.
// Revision: 1.0 - initial release
// ============================================================================
module pbs_lfsr
  import pbs_pkg::*;
#(
  parameter logic [c_LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_stop,
  output logic [c_LFSR_W-1:0] o_state
);

  logic [c_LFSR_W-1:0] r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= SEED;
    end else if (!i_stop) begin
      r_state <= lfsr_next(r_state);
    end
  end

  assign o_state = r_state;

endmodule
`default_nettype wire

// File: rtl/pbs_battle_seq.sv
`default_nettype none
// ============================================================================
// Module  : pbs_battle_seq
// Brief   : One battle turn per start pulse: player move then AI move, with
//           table lookup, accuracy roll, saturating HP subtract, game over.
// Revision: 1.0 - initial release
// ============================================================================
module pbs_battle_seq
  import pbs_pkg::*;
#(
  parameter int                           HP_W     = 4,
  parameter int                           MOVE_W   = 2,
  parameter int                           ACC_W    = 4,
  parameter logic [HP_W*(2**MOVE_W)-1:0]  MOVE_DMG = c_DEF_MOVE_DMG,
  parameter logic [ACC_W*(2**MOVE_W)-1:0] MOVE_ACC = c_DEF_MOVE_ACC,
  parameter logic [15:0]                  SEED     = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic              i_new_game,
  input  logic [MOVE_W-1:0] i_p_move,
  input  logic              i_sure_hit,
  input  logic              i_stop,
  output logic [HP_W-1:0]   o_p_hp,
  output logic [HP_W-1:0]   o_ai_hp,
  output logic [HP_W-1:0]   o_dmg,
  output logic [ACC_W-1:0]  o_accu,
  output logic              o_hit,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_game_over,
  output logic              o_winner
);

  state_t              r_state, w_next;
  logic [MOVE_W-1:0]   r_move;
  logic [HP_W-1:0]     r_p_hp, r_ai_hp, r_dmg;
  logic [ACC_W-1:0]    r_accu;
  logic                r_hit, r_done, r_winner;

  logic [c_LFSR_W-1:0] w_lfsr;
  logic [MOVE_W-1:0]   w_move;
  logic [HP_W-1:0]     w_tbl_dmg, w_tgt_hp, w_new_hp;
  logic [ACC_W-1:0]    w_tbl_acc, w_roll;
  logic                w_tbl_hit, w_hp_zero, w_unused;

  pbs_lfsr #(.SEED(SEED)) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .i_stop  (i_stop),
    .o_state (w_lfsr)
  );

  // Only a few LFSR bits feed the move/roll; fold the rest to keep them referenced
  assign w_unused  = ^w_lfsr;

  assign w_move    = (r_state == A_RES) ? w_lfsr[MOVE_W-1:0] : r_move;
  assign w_tbl_dmg = MOVE_DMG[int'(w_move)*HP_W +: HP_W];
  assign w_tbl_acc = MOVE_ACC[int'(w_move)*ACC_W +: ACC_W];
  assign w_roll    = w_lfsr[ACC_W+7:8];
  assign w_tbl_hit = i_sure_hit | (&w_tbl_acc) | (w_roll < w_tbl_acc);

  assign w_tgt_hp  = (r_state == P_APP) ? r_ai_hp : r_p_hp;
  assign w_new_hp  = !r_hit ? w_tgt_hp : ((r_dmg >= w_tgt_hp) ? '0 : w_tgt_hp - r_dmg);
  assign w_hp_zero = (w_new_hp == '0);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (!i_new_game && i_start) w_next = P_RES;
      P_RES:   w_next = P_APP;
      P_APP:   w_next = w_hp_zero ? OVER : A_RES;
      A_RES:   w_next = A_APP;
      A_APP:   w_next = w_hp_zero ? OVER : IDLE;
      OVER:    if (i_new_game) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_move   <= '0;
      r_p_hp   <= '1;
      r_ai_hp  <= '1;
      r_dmg    <= '0;
      r_accu   <= '0;
      r_hit    <= 1'b0;
      r_done   <= 1'b0;
      r_winner <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          // new_game takes priority; a coincident start is dropped
          if (i_new_game) begin
            r_p_hp  <= '1;
            r_ai_hp <= '1;
          end else if (i_start) begin
            r_move <= i_p_move;
          end
        end
        P_RES, A_RES: begin
          r_dmg  <= w_tbl_dmg;
          r_accu <= w_tbl_acc;
          r_hit  <= w_tbl_hit;
        end
        P_APP: begin
          r_ai_hp <= w_new_hp;
          if (w_hp_zero) begin
            r_winner <= 1'b0;
            r_done   <= 1'b1;
          end
        end
        A_APP: begin
          r_p_hp <= w_new_hp;
          r_done <= 1'b1;
          if (w_hp_zero) r_winner <= 1'b1;
        end
        OVER: begin
          if (i_new_game) begin
            r_p_hp  <= '1;
            r_ai_hp <= '1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_p_hp      = r_p_hp;
  assign o_ai_hp     = r_ai_hp;
  assign o_dmg       = r_dmg;
  assign o_accu      = r_accu;
  assign o_hit       = r_hit;
  assign o_done      = r_done;
  assign o_winner    = r_winner;
  assign o_game_over = (r_state == OVER);
  assign o_busy      = (r_state != IDLE) && (r_state != OVER);

endmodule
`default_nettype wire

// File: tb/tb_pbs_battle_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_pbs_battle_seq
// Brief   : Scoreboard bench for pbs_battle_seq against a turn-level model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_pbs_battle_seq;

  localparam logic [15:0] C_SEED = 16'hACE1;
  localparam logic [15:0] C_DMG  = {4'd7, 4'd5, 4'd3, 4'd1};
  // move0 accuracy 0 (never hits), move2 accuracy all ones (always hits)
  localparam logic [15:0] C_ACC  = {4'd8, 4'd15, 4'd11, 4'd0};

  int dmg_tab [4] = '{1, 3, 5, 7};
  int acc_tab [4] = '{0, 11, 15, 8};

  logic       clk = 1'b0, rst = 1'b1;
  logic       i_start = 1'b0, i_new_game = 1'b0, i_sure_hit = 1'b0, i_stop = 1'b0;
  logic [1:0] i_p_move = 2'd0;
  logic [3:0] o_p_hp, o_ai_hp, o_dmg, o_accu;
  logic       o_hit, o_busy, o_done, o_game_over, o_winner;

  pbs_battle_seq #(
    .HP_W(4), .MOVE_W(2), .ACC_W(4),
    .MOVE_DMG(C_DMG), .MOVE_ACC(C_ACC), .SEED(C_SEED)
  ) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_new_game(i_new_game),
    .i_p_move(i_p_move), .i_sure_hit(i_sure_hit), .i_stop(i_stop),
    .o_p_hp(o_p_hp), .o_ai_hp(o_ai_hp), .o_dmg(o_dmg), .o_accu(o_accu),
    .o_hit(o_hit), .o_busy(o_busy), .o_done(o_done),
    .o_game_over(o_game_over), .o_winner(o_winner)
  );

  always #5 clk = ~clk;

  typedef struct {
    int php; int aihp; int dmg; int accu;
    bit hit; bit over; bit winner; int cyc;
  } exp_t;

  exp_t        q[$];
  int          checks = 0, errors = 0, cyc = 0;
  int          m_php = 15, m_aihp = 15;
  bit          m_over = 1'b0;
  logic [15:0] m_lfsr = C_SEED;

  function automatic logic [15:0] step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  function automatic int hp_after(input int hp, input int d, input bit h);
    if (!h) return hp;
    return (d >= hp) ? 0 : hp - d;
  endfunction

  function automatic bit hits(input int a, input int roll, input bit sh);
    return sh || (a == 15) || (roll < a);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Random source rule: advances every cycle unless frozen, restarts on reset
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst)          m_lfsr <= C_SEED;
    else if (!i_stop) m_lfsr <= step(m_lfsr);
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && o_done === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_done", o_done, 0);
      end else begin
        e = q.pop_front();
        chk("done_cycle", cyc, e.cyc);
        chk("p_hp", o_p_hp, e.php);
        chk("ai_hp", o_ai_hp, e.aihp);
        chk("dmg", o_dmg, e.dmg);
        chk("accu", o_accu, e.accu);
        chk("hit", o_hit, e.hit);
        chk("game_over", o_game_over, e.over);
        if (e.over) chk("winner", o_winner, e.winner);
      end
    end
  end

  task automatic wait_drain();
    int lim = 0;
    while (q.size() != 0 && lim < 12) begin
      tick(1);
      lim++;
    end
    if (q.size() != 0) begin
      chk("done_timeout", q.size(), 0);
      q.delete();
    end
  endtask

  task automatic run_turn(input logic [1:0] mv, input bit sh, input bit noise);
    exp_t        e;
    logic [15:0] l;
    int          a, d, am, pl_dmg, ai_after_p;
    bit          h, pl_hit, ko;
    l = step(m_lfsr);
    a = acc_tab[mv];
    d = dmg_tab[mv];
    h = hits(a, int'(l[11:8]), sh);
    pl_dmg = d; pl_hit = h;
    m_aihp = hp_after(m_aihp, d, h);
    ai_after_p = m_aihp;
    e.dmg = d; e.accu = a; e.hit = h; e.over = 1'b0; e.winner = 1'b0;
    ko = (m_aihp == 0);
    if (ko) begin
      e.over = 1'b1;
      e.cyc  = cyc + 3;
    end else begin
      l  = step(step(l));
      am = int'(l[1:0]);
      a  = acc_tab[am];
      d  = dmg_tab[am];
      h  = hits(a, int'(l[11:8]), sh);
      m_php = hp_after(m_php, d, h);
      e.dmg = d; e.accu = a; e.hit = h;
      e.cyc = cyc + 5;
      if (m_php == 0) begin
        e.over = 1'b1;
        e.winner = 1'b1;
      end
    end
    m_over = e.over;
    e.php = m_php;
    e.aihp = m_aihp;
    q.push_back(e);
    i_start = 1'b1; i_p_move = mv; i_sure_hit = sh; i_stop = 1'b0; i_new_game = 1'b0;
    tick(1);
    i_start = 1'b0;
    for (int k = 1; k <= (ko ? 2 : 4); k++) begin
      if (k == 1) chk("busy_mid", o_busy, 1);
      if (k == 2) begin
        chk("player_hit", o_hit, pl_hit);
        chk("player_dmg", o_dmg, pl_dmg);
      end
      if (k == 3) chk("ai_hp_after_player", o_ai_hp, ai_after_p);
      if (noise) begin
        i_start    = 1'($urandom);
        i_new_game = 1'($urandom);
        i_p_move   = 2'($urandom);
      end
      tick(1);
    end
    i_start = 1'b0;
    i_new_game = 1'b0;
    wait_drain();
  endtask

  task automatic finish_game();
    chk("over_level", o_game_over, 1);
    chk("over_not_busy", o_busy, 0);
    i_start = 1'b1;
    tick(1);
    i_start = 1'b0;
    tick(2);
    chk("start_in_over_ignored", o_game_over, 1);
    i_new_game = 1'b1;
    tick(1);
    i_new_game = 1'b0;
    m_php = 15; m_aihp = 15; m_over = 1'b0;
    chk("ng_p_hp", o_p_hp, 15);
    chk("ng_ai_hp", o_ai_hp, 15);
    chk("ng_over_clear", o_game_over, 0);
  endtask

  initial begin
    logic [15:0] snap;
    rst = 1'b1;
    tick(2);
    chk("rst_p_hp", o_p_hp, 15);
    chk("rst_ai_hp", o_ai_hp, 15);
    chk("rst_busy", o_busy, 0);
    chk("rst_over", o_game_over, 0);
    chk("rst_done", o_done, 0);
    chk("rst_dmg", o_dmg, 0);
    chk("rst_hit", o_hit, 0);
    rst = 1'b0;
    tick(1);

    // Sure-hit turns drive AI HP 15 -> 10 -> 3 -> 0
    run_turn(2'd2, 1'b1, 1'b0);
    run_turn(2'd3, 1'b1, 1'b1);
    run_turn(2'd2, 1'b1, 1'b0);
    if (m_over) finish_game();

    // Zero-accuracy move without sure_hit must miss
    run_turn(2'd0, 1'b0, 1'b1);
    if (m_over) finish_game();

    // new_game and start together in IDLE: restore HP, no turn
    i_new_game = 1'b1; i_start = 1'b1; i_p_move = 2'd3;
    tick(1);
    i_new_game = 1'b0; i_start = 1'b0;
    m_php = 15; m_aihp = 15;
    chk("ng_start_not_busy", o_busy, 0);
    chk("ng_start_p_hp", o_p_hp, 15);
    chk("ng_start_ai_hp", o_ai_hp, 15);
    tick(6);

    // Reset during A_RES
    i_start = 1'b1; i_p_move = 2'd1; i_sure_hit = 1'b1;
    tick(1);
    i_start = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(1);
    chk("midrst_p_hp", o_p_hp, 15);
    chk("midrst_ai_hp", o_ai_hp, 15);
    chk("midrst_dmg", o_dmg, 0);
    chk("midrst_busy", o_busy, 0);
    chk("midrst_done", o_done, 0);
    rst = 1'b0;
    m_php = 15; m_aihp = 15; m_over = 1'b0;
    tick(6);

    // Freeze the random source
    i_stop = 1'b1;
    tick(1);
    snap = m_lfsr;
    chk("lfsr_track", dut.w_lfsr, m_lfsr);
    tick(10);
    chk("lfsr_held", dut.w_lfsr, snap);
    i_stop = 1'b0;
    tick(1);

    for (int t = 0; t < 40; t++) begin
      int gap;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        i_stop = 1'($urandom);
        tick(1);
      end
      run_turn(2'($urandom), 1'($urandom), 1'b1);
      if (m_over) finish_game();
    end

    tick(4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
